msk_prbs_sync_checker: RTL and testbench
========================================

// Module: msk_prbs_sync_checker
// PURPOSE
//  Self-synchronising bit-error checker for the MSK RX demod outputs (slicer, CFO slicer, oversampled demod).
//  Finds a known cyclic test pattern in the recovered bit stream and resolves the demod polarity ambiguity.
//  Once locked, counts bit errors and pattern slips. Synthesisable successor to the sim-only bit viewer.
//  Gives pass/fail and BER counters in both simulation and on hardware.
// PARAMETERS
//  PAT_W        256   pattern length in bits; transmitted MSB first, repeats cyclically
//  PATTERN      256'h901000000033000000FFFFFFFF010000007700ffff00000001010000ffa50ffe  reference pattern
//  SYNC_W       32    sync word = PATTERN[PAT_W-1 -: SYNC_W]; must be unique in the rotated pattern (PAT_W>SYNC_W>=8)
//  VERIFY_BITS  64    number of consecutive error-free bits after sync that are needed to declare lock
//  WIN          128   error-monitor window length in bits while locked
//  LOSS_THR     16    lock is dropped when errors in one window exceed this value
//  CNT_W        32    width of the bit, error and loss counters
// PORTS
//  clk          in   1          system clock
//  reset_n      in   1          asynchronous reset, active low
//  data_i       in   1          recovered bit
//  data_val_i   in   1          data_i valid strobe; may be asserted back-to-back or sparsely
//  clear_i      in   1          synchronous clear of bit_cnt_o/err_cnt_o/loss_cnt_o; does not touch lock
//  lock_o       out  1          high in LOCKED
//  inverted_o   out  1          stream matched ~PATTERN (polarity latched at sync)
//  state_o      out  2          0=SEARCH 1=VERIFY 2=LOCKED
//  err_pulse_o  out  1          1-cycle pulse: locked bit mismatched
//  bit_cnt_o    out  CNT_W      bits checked while LOCKED, saturating
//  err_cnt_o    out  CNT_W      bit errors while LOCKED, saturating
//  loss_cnt_o   out  CNT_W      LOCKED->SEARCH transitions, saturating
// BEHAVIOUR
//  Reset: all outputs and counters 0; state SEARCH; shift register 0; pointer 0; inverted 0.
//  Only cycles with data_val_i=1 advance any logic. All outputs are registered, with 1-cycle latency from the strobe.
//  SEARCH:
//   - Shift data_i into an SYNC_W-bit register (newest bit = LSB).
//   - Compare the shifted value, including the current bit, against the sync word and its inverse.
//   - True match: go to VERIFY with inv=0. Inverse match: go to VERIFY with inv=1.
//   - On either match, load ptr=SYNC_W mod PAT_W and clear the verify count.
//   - A true match wins if both would match.
//  VERIFY:
//   - Expected bit = PATTERN[PAT_W-1-ptr]^inv.
//   - Mismatch: go to SEARCH and clear the shift register. No counters change.
//   - Match: verify count +1. After VERIFY_BITS matches, go to LOCKED and clear the window counters.
//  LOCKED:
//   - Each bit: bit_cnt+1. On mismatch: err_cnt+1, err_pulse_o=1, win_err+1.
//   - Window bit count runs 0..WIN-1. On the bit that completes the window, clear win_err to 0.
//   - An error on that same completing bit is evaluated first, so it counts in the closing window.
//   - If win_err would exceed LOSS_THR: go to SEARCH, loss_cnt+1, clear the shift register and the window.
//   - The bit that causes the loss is still counted in bit_cnt and err_cnt.
//  ptr increments on each valid bit in VERIFY and LOCKED, wrapping from PAT_W-1 to 0.
//  Counters saturate at all-ones and do not wrap.
//  clear_i together with data_val_i: clear takes priority. Counters read 0 afterwards; that bit is not counted.
//  inverted_o holds its value through SEARCH until the next sync match.
//  Reset asserted mid-operation forces the reset state immediately; no partial counts survive.
// TESTING
//  1. PATTERN cyclic from offset 0, data_val every 20 clk:
//     -> VERIFY after bit 32; lock_o after bit 96; err_cnt 0; bit_cnt = N-96 after N bits.
//  2. ~PATTERN starting at offset 100 (bit 100 first):
//     -> sync at the first pattern head; inverted_o=1; lock; err_cnt 0.
//  3. Locked, flip one bit -> err_pulse_o for 1 cycle, err_cnt=1, lock_o stays 1.
//  4. Locked, 17 errors within one 128-bit window:
//     -> state SEARCH on the 17th error, loss_cnt=1, err_cnt=17; relock 96 bits after the next sync head.
//  5. 16 errors at the end of window k, then 16 at the start of window k+1 -> lock held, err_cnt=32.
//  6. clear_i coincident with data_val_i while locked:
//     -> counters 0 next cycle, lock held.
//     Deassert reset_n mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/msk_prbs_sync_checker.sv
// Self-synchronising bit-error checker for the MSK RX demod bit stream.
// Finds a cyclic reference pattern (either polarity), verifies it, then counts bit errors and lock losses.
module msk_prbs_sync_checker #(
  parameter int unsigned       PAT_W       = 256,
  parameter logic [PAT_W-1:0]  PATTERN     = 256'h901000000033000000FFFFFFFF010000007700ffff00000001010000ffa50ffe,
  parameter int unsigned       SYNC_W      = 32,
  parameter int unsigned       VERIFY_BITS = 64,
  parameter int unsigned       WIN         = 128,
  parameter int unsigned       LOSS_THR    = 16,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             clear_i,
  output logic             lock_o,
  output logic             inverted_o,
  output logic [1:0]       state_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned PTR_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned VCNT_W = $clog2(VERIFY_BITS + 1);
  localparam int unsigned WPOS_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WERR_W = $clog2(LOSS_THR + 2);
  localparam int unsigned HIST_W = SYNC_W - 1;

  localparam logic [SYNC_W-1:0] SYNC_WORD = PATTERN[PAT_W-1 -: SYNC_W];
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PAT_W - 1);
  localparam logic [PTR_W-1:0]  PTR_SYNC  = PTR_W'(SYNC_W % PAT_W);
  localparam logic [WPOS_W-1:0] WPOS_LAST = WPOS_W'(WIN - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               lock_q, lock_d;
  logic               inv_q, inv_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
  logic [WPOS_W-1:0]  wpos_q, wpos_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

  // Only the SYNC_W-1 older bits are stored; the current bit completes the word.
  logic [SYNC_W-1:0]  sh_word;
  logic [PTR_W-1:0]   ptr_rev;
  logic [PTR_W-1:0]   ptr_inc;
  logic [VCNT_W-1:0]  vcnt_inc;
  logic               bit_err;

  assign sh_word  = {hist_q, data_i};
  assign ptr_rev  = PTR_LAST - ptr_q;
  assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign vcnt_inc = vcnt_q + VCNT_W'(1);
  assign bit_err  = data_i ^ (PATTERN[ptr_rev] ^ inv_q);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and datapath update.
  always_comb begin
    logic [WERR_W-1:0] werr_nxt;
    state_d    = state_q;
    inv_d      = inv_q;
    hist_d     = hist_q;
    ptr_d      = ptr_q;
    vcnt_d     = vcnt_q;
    wpos_d     = wpos_q;
    werr_d     = werr_q;
    pulse_d    = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    loss_cnt_d = loss_cnt_q;
    werr_nxt   = werr_q;

    if (data_val_i) begin
      case (state_q)
        ST_SEARCH: begin
          hist_d = sh_word[HIST_W-1:0];
          if (sh_word == SYNC_WORD) begin
            state_d = ST_VERIFY;
            inv_d   = 1'b0;
            ptr_d   = PTR_SYNC;
            vcnt_d  = '0;
          end else if (sh_word == ~SYNC_WORD) begin
            state_d = ST_VERIFY;
            inv_d   = 1'b1;
            ptr_d   = PTR_SYNC;
            vcnt_d  = '0;
          end
        end
        ST_VERIFY: begin
          ptr_d = ptr_inc;
          if (bit_err) begin
            state_d = ST_SEARCH;
            hist_d  = '0;
          end else begin
            vcnt_d = vcnt_inc;
            if (vcnt_inc == VCNT_W'(VERIFY_BITS)) begin
              state_d = ST_LOCKED;
              wpos_d  = '0;
              werr_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          ptr_d     = ptr_inc;
          bit_cnt_d = sat_inc(bit_cnt_q);
          if (bit_err) begin
            err_cnt_d = sat_inc(err_cnt_q);
            pulse_d   = 1'b1;
            werr_nxt  = werr_q + WERR_W'(1);
          end
          // An error on the window-closing bit is judged before the window resets.
          if (werr_nxt > WERR_W'(LOSS_THR)) begin
            state_d    = ST_SEARCH;
            loss_cnt_d = sat_inc(loss_cnt_q);
            hist_d     = '0;
            wpos_d     = '0;
            werr_d     = '0;
          end else if (wpos_q == WPOS_LAST) begin
            wpos_d = '0;
            werr_d = '0;
          end else begin
            wpos_d = wpos_q + WPOS_W'(1);
            werr_d = werr_nxt;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          hist_d  = '0;
        end
      endcase
    end

    if (clear_i) begin
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
      loss_cnt_d = '0;
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SEARCH;
      lock_q     <= 1'b0;
      inv_q      <= 1'b0;
      hist_q     <= '0;
      ptr_q      <= '0;
      vcnt_q     <= '0;
      wpos_q     <= '0;
      werr_q     <= '0;
      pulse_q    <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      inv_q      <= inv_d;
      hist_q     <= hist_d;
      ptr_q      <= ptr_d;
      vcnt_q     <= vcnt_d;
      wpos_q     <= wpos_d;
      werr_q     <= werr_d;
      pulse_q    <= pulse_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_o      = lock_q;
  assign inverted_o  = inv_q;
  assign state_o     = state_q;
  assign err_pulse_o = pulse_q;
  assign bit_cnt_o   = bit_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign loss_cnt_o  = loss_cnt_q;

endmodule

// File: tb/tb_msk_prbs_sync_checker.sv
// Scoreboard bench for msk_prbs_sync_checker: a queue-based reference model predicts every strobed
// response; a monitor compares it one cycle after each strobe. Directed checks cover the key scenarios.
module tb_msk_prbs_sync_checker;
  localparam int unsigned PAT_W = 256, SYNC_W = 32, VERIFY_BITS = 64, WIN = 128, LOSS_THR = 16, CNT_W = 32;
  localparam logic [PAT_W-1:0] PATTERN =
    256'h901000000033000000FFFFFFFF010000007700ffff00000001010000ffa50ffe;
  localparam longint CMAX = longint'((64'd1 << CNT_W) - 64'd1);

  logic clk = 1'b0, reset_n = 1'b0, data_i = 1'b0, data_val_i = 1'b0, clear_i = 1'b0;
  logic lock_o, inverted_o, err_pulse_o;
  logic [1:0] state_o;
  logic [CNT_W-1:0] bit_cnt_o, err_cnt_o, loss_cnt_o;

  msk_prbs_sync_checker #(
    .PAT_W(PAT_W), .PATTERN(PATTERN), .SYNC_W(SYNC_W), .VERIFY_BITS(VERIFY_BITS),
    .WIN(WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_val_i(data_val_i), .clear_i(clear_i),
    .lock_o(lock_o), .inverted_o(inverted_o), .state_o(state_o), .err_pulse_o(err_pulse_o),
    .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lock; logic inv; logic [1:0] st; logic pulse;
    logic [CNT_W-1:0] bits; logic [CNT_W-1:0] errs; logic [CNT_W-1:0] loss;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int total = 0, bad = 0;

  // Reference model: pattern as a bit array (index 0 = first transmitted bit).
  bit     pat[PAT_W];
  bit     md_hist[$];
  int     md_mode, md_ptr, md_vcnt, md_wpos, md_werr;
  bit     md_inv, md_pulse;
  longint md_bits, md_errs, md_loss;
  int     src_pos;
  bit     src_inv;

  function automatic void clear_hist();
    md_hist.delete();
    for (int k = 0; k < SYNC_W; k++) md_hist.push_back(1'b0);
  endfunction

  function automatic void model_reset();
    clear_hist();
    md_mode = 0; md_ptr = 0; md_vcnt = 0; md_wpos = 0; md_werr = 0;
    md_inv = 0; md_pulse = 0; md_bits = 0; md_errs = 0; md_loss = 0;
  endfunction

  function automatic bit hist_matches(input bit want_inv);
    for (int k = 0; k < SYNC_W; k++) if (md_hist[k] != (pat[k] ^ want_inv)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint sat(input longint v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic void model_step(input bit d, input bit val, input bit clr);
    bit e;
    md_pulse = 0;
    if (val) begin
      if (md_mode == 0) begin
        void'(md_hist.pop_front());
        md_hist.push_back(d);
        if (hist_matches(1'b0)) begin
          md_mode = 1; md_inv = 0; md_ptr = SYNC_W % PAT_W; md_vcnt = 0;
        end else if (hist_matches(1'b1)) begin
          md_mode = 1; md_inv = 1; md_ptr = SYNC_W % PAT_W; md_vcnt = 0;
        end
      end else if (md_mode == 1) begin
        e = pat[md_ptr] ^ md_inv;
        md_ptr = (md_ptr + 1) % PAT_W;
        if (d != e) begin
          md_mode = 0; clear_hist();
        end else begin
          md_vcnt++;
          if (md_vcnt == VERIFY_BITS) begin md_mode = 2; md_wpos = 0; md_werr = 0; end
        end
      end else begin
        e = pat[md_ptr] ^ md_inv;
        md_ptr = (md_ptr + 1) % PAT_W;
        md_bits = sat(md_bits);
        if (d != e) begin md_errs = sat(md_errs); md_pulse = 1; md_werr++; end
        if (md_werr > LOSS_THR) begin
          md_mode = 0; md_loss = sat(md_loss); clear_hist(); md_wpos = 0; md_werr = 0;
        end else if (md_wpos == WIN - 1) begin
          md_wpos = 0; md_werr = 0;
        end else begin
          md_wpos++;
        end
      end
    end
    if (clr) begin md_bits = 0; md_errs = 0; md_loss = 0; end
  endfunction

  function automatic void push_exp();
    obs_t e;
    e.lock = (md_mode == 2); e.inv = md_inv; e.st = 2'(md_mode); e.pulse = md_pulse;
    e.bits = CNT_W'(md_bits); e.errs = CNT_W'(md_errs); e.loss = CNT_W'(md_loss);
    exp_q.push_back(e);
  endfunction

  // Monitor: every strobe produces one registered response visible after the next edge.
  always @(posedge clk) begin
    if (reset_n && (data_val_i || clear_i)) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow actual=response required=expectation");
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = {lock_o, inverted_o, state_o, err_pulse_o, bit_cnt_o, err_cnt_o, loss_cnt_o};
        if (mon_a !== mon_e)
          $display("FAIL out_cmp t=%0t actual lock=%0d inv=%0d st=%0d pulse=%0d bits=%0d errs=%0d loss=%0d required lock=%0d inv=%0d st=%0d pulse=%0d bits=%0d errs=%0d loss=%0d",
                   $time, mon_a.lock, mon_a.inv, mon_a.st, mon_a.pulse, mon_a.bits, mon_a.errs, mon_a.loss,
                   mon_e.lock, mon_e.inv, mon_e.st, mon_e.pulse, mon_e.bits, mon_e.errs, mon_e.loss);
        if (mon_a !== mon_e) bad++;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send(input bit d, input bit clr);
    @(negedge clk);
    data_i = d; data_val_i = 1'b1; clear_i = clr;
    model_step(d, 1'b1, clr);
    push_exp();
  endtask

  task automatic clr_only();
    @(negedge clk);
    data_i = 1'b0; data_val_i = 1'b0; clear_i = 1'b1;
    model_step(1'b0, 1'b0, 1'b1);
    push_exp();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_val_i = 1'b0; clear_i = 1'b0;
    for (int k = 1; k < n; k++) @(negedge clk);
  endtask

  task automatic send_src(input bit flip, input int gap);
    bit b;
    b = pat[src_pos] ^ src_inv ^ flip;
    src_pos = (src_pos + 1) % PAT_W;
    send(b, 1'b0);
    if (gap > 0) idle(gap);
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk); #3;
    reset_n = 1'b0; #1;
    chk({tag, "_lock"}, lock_o, 0);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_inv_pulse"}, {inverted_o, err_pulse_o}, 0);
    chk({tag, "_cnts"}, bit_cnt_o | err_cnt_o | loss_cnt_o, 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    logic [PAT_W-1:0] pv;
    pv = PATTERN;
    for (int k = 0; k < PAT_W; k++) pat[k] = pv[PAT_W-1-k];
    model_reset();
    src_pos = 0; src_inv = 0;

    repeat (3) @(negedge clk);
    chk("rst_lock", lock_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_cnts", bit_cnt_o | err_cnt_o | loss_cnt_o, 0);
    reset_n = 1'b1;

    // Random noise while searching.
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    async_reset_check("rst_async_noise");

    // Clean pattern from offset 0, sparse strobes.
    src_pos = 0; src_inv = 0;
    for (int i = 0; i < 32; i++) send_src(1'b0, 20);
    chk("t1_verify_at32", state_o, 1);
    for (int i = 0; i < 63; i++) send_src(1'b0, 20);
    chk("t1_nolock_at95", lock_o, 0);
    send_src(1'b0, 20);
    chk("t1_lock_at96", lock_o, 1);
    chk("t1_bits_at96", bit_cnt_o, 0);
    for (int i = 0; i < 40; i++) send_src(1'b0, 20);
    chk("t1_bits_at136", bit_cnt_o, 40);
    chk("t1_errs", err_cnt_o, 0);

    // Single flipped bit while locked.
    for (int i = 0; i < 10; i++) send_src(1'b0, 0);
    send_src(1'b1, 0);
    idle(1);
    chk("t3_pulse_on", err_pulse_o, 1);
    idle(1);
    chk("t3_pulse_off", err_pulse_o, 0);
    chk("t3_errs", err_cnt_o, 1);
    chk("t3_lock", lock_o, 1);

    // 17 errors inside one window drop lock.
    clr_only();
    for (int i = 0; i < 400 && md_wpos != 0; i++) send_src(1'b0, 0);
    for (int i = 0; i < 17; i++) begin send_src(1'b1, 0); send_src(1'b0, 0); end
    idle(2);
    chk("t4_state", state_o, 0);
    chk("t4_loss", loss_cnt_o, 1);
    chk("t4_errs", err_cnt_o, 17);
    for (int i = 0; i < 300 && src_pos != 0; i++) send_src(1'b0, 0);
    for (int i = 0; i < 95; i++) send_src(1'b0, 0);
    idle(1);
    chk("t4_nolock_95", lock_o, 0);
    send_src(1'b0, 1);
    chk("t4_relock_96", lock_o, 1);

    // 16 errors at the end of one window and 16 at the start of the next.
    clr_only();
    for (int i = 0; i < 400 && md_wpos != WIN - 16; i++) send_src(1'b0, 0);
    for (int i = 0; i < 32; i++) send_src(1'b1, 0);
    for (int i = 0; i < 20; i++) send_src(1'b0, 0);
    idle(2);
    chk("t5_lock", lock_o, 1);
    chk("t5_errs", err_cnt_o, 32);

    // Clear coincident with a strobe.
    for (int i = 0; i < 5; i++) send_src(1'b0, 0);
    begin
      bit b;
      b = pat[src_pos] ^ src_inv;
      src_pos = (src_pos + 1) % PAT_W;
      send(b, 1'b1);
    end
    idle(2);
    chk("t6_cnts", bit_cnt_o | err_cnt_o | loss_cnt_o, 0);
    chk("t6_lock", lock_o, 1);
    send_src(1'b0, 2);
    chk("t6_bits_after", bit_cnt_o, 1);

    async_reset_check("rst_async_lock");

    // Inverted pattern starting at bit 100.
    src_pos = 100; src_inv = 1;
    for (int i = 0; i < 251; i++) send_src(1'b0, $urandom_range(0, 1));
    idle(1);
    chk("t2_nolock_251", lock_o, 0);
    send_src(1'b0, 1);
    chk("t2_lock_252", lock_o, 1);
    chk("t2_inverted", inverted_o, 1);
    chk("t2_errs", err_cnt_o, 0);

    // Randomised errors, gaps and clears: light, heavy (forces loss), then clean.
    for (int i = 0; i < 1800; i++) begin
      int rate;
      rate = (i < 1000) ? 3 : (i < 1250) ? 25 : 0;
      if ($urandom_range(0, 299) == 0) begin
        bit b;
        b = pat[src_pos] ^ src_inv;
        src_pos = (src_pos + 1) % PAT_W;
        send(b, 1'b1);
      end else begin
        send_src(1'($urandom_range(0, 99) < rate), 0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
